// File: rtl/axi4s_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
package axi4s_pkg;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_DISCARD = 1'b1
    } pkt_state_e;

    localparam int PTR_MAX_W = 32;

    // Modular pointer distance; callers truncate the result to their pointer width.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(input logic [PTR_MAX_W-1:0] a,
                                                      input logic [PTR_MAX_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module sdp_ram #(
    parameter int W  = 34,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; it doubles as the stream output register of the FIFO.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4s_pkt_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode that drops
// errored or oversize packets by rewinding the write pointer to the last commit.
module axi4s_pkt_fifo
    import axi4s_pkg::*;
#(
    parameter int DW       = 32,
    parameter int UW       = 1,
    parameter int AW       = 4,
    parameter int PKT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] s_tdata,
    input  logic [UW-1:0] s_tuser,
    input  logic          s_tlast,
    input  logic          s_terr,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic [UW-1:0] m_tuser,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [AW:0]   level,
    output logic          pkt_drop
);

    localparam int PW = AW + 1;
    localparam int W  = DW + UW + 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

    logic [AW:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d, level_q;
    pkt_state_e  state_q, state_d;
    logic        m_tvalid_q, m_tvalid_d, pkt_drop_q, pkt_drop_d;
    logic [AW:0] used_s;
    logic        full_s, empty_s, s_tready_s, accept_s, wr_s, rd_s;
    logic [W-1:0] ram_rdata_s;

    assign used_s   = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q)));
    assign full_s   = (used_s == DEPTH);
    assign empty_s  = (rd_ptr_q == wr_commit_q);
    assign accept_s = s_tvalid & s_tready_s;
    assign wr_s     = accept_s & (state_q == ST_FILL);
    assign rd_s     = ~empty_s & (~m_tvalid_q | m_tready);

    // Sink ready: held low in reset, always open while discarding an oversize packet.
    always_comb begin
        s_tready_s = 1'b0;
        if (!reset_n) begin
            s_tready_s = 1'b0;
        end else if (state_q == ST_DISCARD) begin
            s_tready_s = 1'b1;
        end else begin
            s_tready_s = ~full_s;
        end
    end

    // Write side: pointer advance, commit/rewind and the FILL/DISCARD FSM.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        pkt_drop_d  = 1'b0;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (PKT_MODE == 0) begin
            wr_commit_d = wr_ptr_d;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_s && s_tlast) begin
                        if (s_terr) begin
                            wr_ptr_d   = wr_commit_q;
                            pkt_drop_d = 1'b1;
                        end else begin
                            wr_commit_d = wr_ptr_q + PTR_ONE;
                        end
                    end else if (full_s && (wr_commit_q == rd_ptr_q)) begin
                        // RAM is entirely one unfinished packet: it can never fit.
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_DISCARD: begin
                    if (accept_s && s_tlast) begin
                        wr_ptr_d   = wr_commit_q;
                        pkt_drop_d = 1'b1;
                        state_d    = ST_FILL;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // Read side: output register refill and valid tracking.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        m_tvalid_d = m_tvalid_q;
        if (rd_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // State, pointer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            m_tvalid_q  <= 1'b0;
            pkt_drop_q  <= 1'b0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            m_tvalid_q  <= m_tvalid_d;
            pkt_drop_q  <= pkt_drop_d;
            level_q     <= PW'(ptr_diff(32'(wr_ptr_d), 32'(rd_ptr_d)));
        end
    end

    sdp_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({s_tdata, s_tuser, s_tlast}),
        .re_i    (rd_s),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata_s)
    );

    assign {m_tdata, m_tuser, m_tlast} = ram_rdata_s;
    assign s_tready = s_tready_s;
    assign m_tvalid = m_tvalid_q;
    assign level    = level_q;
    assign pkt_drop = pkt_drop_q;

endmodule
